// File: rtl/arm_pipe_scoreboard.sv
// arm_pipe_scoreboard: hazard/scoreboard unit that sits beside the ID stage of the ARM pipeline.
// It tracks in-flight register writes in a DEPTH-entry shift register. Slot 0 is EXE and slot
// DEPTH-1 is the last stage before the register-file write. From these entries it drives the
// IF/ID freeze, the optional forwarding selects and a saturating stall counter.
//
// Optional feature: define ARM_PIPE_FWD_EN to enable operand forwarding. With forwarding, only
// load-use stalls remain. Without it (the default build), any in-flight write to a source stalls.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   id_valid_i     ID holds a real instruction
//   id_src1_i      first source register (Rn)
//   id_src2_i      second source register (Rm, or Rd for STR)
//   id_two_src_i   id_src2_i is live
//   id_wb_en_i     ID instruction writes id_dest_i
//   id_mem_r_en_i  ID instruction is a load
//   id_dest_i      ID destination register
//   flush_i        branch taken in EXE; squash the ID instruction
//   hazard_o       freeze PC + IF/ID, bubble into ID/EXE
//   fwd_sel1_o     src1 source: 0 = register file, k = result of slot k-1
//   fwd_sel2_o     src2 source, same encoding
//   inflight_o     number of valid writing slots (registered)
//   stall_count_o  saturating count of hazard cycles
module arm_pipe_scoreboard #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_src1_i,
  input  logic [REG_AW-1:0] id_src2_i,
  input  logic              id_two_src_i,
  input  logic              id_wb_en_i,
  input  logic              id_mem_r_en_i,
  input  logic [REG_AW-1:0] id_dest_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic [3:0]        fwd_sel1_o,
  output logic [3:0]        fwd_sel2_o,
  output logic [3:0]        inflight_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  typedef struct packed {
    logic              v;
    logic              wb;
    logic              ld;
    logic [REG_AW-1:0] dest;
  } entry_t;

  entry_t [DEPTH-1:0] slot_q, slot_d;
  logic   [3:0]       inflight_q, inflight_d;
  logic   [CNT_W-1:0] stall_q, stall_d;

  logic [DEPTH-1:0] match1, match2;
  logic             id_live;

  assign id_live = id_valid_i & ~flush_i;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = slot_q[i].v & slot_q[i].wb & (slot_q[i].dest == id_src1_i);
      match2[i] = slot_q[i].v & slot_q[i].wb & id_two_src_i & (slot_q[i].dest == id_src2_i);
    end
  end

`ifdef ARM_PIPE_FWD_EN
  // Only a load sitting in EXE cannot be forwarded yet: one bubble resolves it.
  assign hazard_o = id_live & slot_q[0].ld & (match1[0] | match2[0]);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_sel1_o = 4'd0;
    fwd_sel2_o = 4'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) fwd_sel1_o = 4'(i + 1);
      if (match2[i]) fwd_sel2_o = 4'(i + 1);
    end
    if (hazard_o) begin
      fwd_sel1_o = 4'd0;
      fwd_sel2_o = 4'd0;
    end
  end
`else
  assign hazard_o   = id_live & ((|match1) | (|match2));
  assign fwd_sel1_o = 4'd0;
  assign fwd_sel2_o = 4'd0;
`endif

  always_comb begin
    slot_d = slot_q;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      slot_d[i] = slot_q[i-1];
    end
    // A stalled or squashed instruction leaves a bubble in EXE.
    slot_d[0] = '0;
    if (id_live && !hazard_o) begin
      slot_d[0].v    = 1'b1;
      slot_d[0].wb   = id_wb_en_i;
      slot_d[0].ld   = id_mem_r_en_i;
      slot_d[0].dest = id_dest_i;
    end
  end

  always_comb begin
    inflight_d = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_d = inflight_d + {3'b000, slot_d[i].v & slot_d[i].wb};
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard_o && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q     <= '0;
      inflight_q <= 4'd0;
      stall_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

  assign inflight_o    = inflight_q;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_arm_pipe_scoreboard.sv
// Bench for arm_pipe_scoreboard (DEPTH=2, CNT_W=2 so saturation is reachable quickly).
// A behavioural model of the in-flight writes is checked against the DUT every cycle. Directed
// instruction sequences add literal expectations for the selected build (ARM_PIPE_FWD_EN or not).
module tb_arm_pipe_scoreboard;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int          SMAX  = (1 << CNT_W) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_src1, id_src2, id_dest;
  logic          id_two_src, id_wb_en, id_mem_r_en, flush;
  logic          hazard;
  logic [3:0]    fwd_sel1, fwd_sel2, inflight;
  logic [CNT_W-1:0] stall_count;

  arm_pipe_scoreboard #(
    .REG_AW(AW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_src1_i    (id_src1),
    .id_src2_i    (id_src2),
    .id_two_src_i (id_two_src),
    .id_wb_en_i   (id_wb_en),
    .id_mem_r_en_i(id_mem_r_en),
    .id_dest_i    (id_dest),
    .flush_i      (flush),
    .hazard_o     (hazard),
    .fwd_sel1_o   (fwd_sel1),
    .fwd_sel2_o   (fwd_sel2),
    .inflight_o   (inflight),
    .stall_count_o(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight writes, index 0 = youngest (EXE).
  bit            mv [DEPTH];
  bit            mwb[DEPTH];
  bit            mld[DEPTH];
  logic [AW-1:0] md [DEPTH];
  int            mstall   = 0;
  bit            model_on = 0;
  bit            exp_haz  = 0;

  always @(negedge clk) begin
    bit h;
    int f1, f2, inf;
    h = 0; f1 = 0; f2 = 0; inf = 0;
    for (int i = 0; i < DEPTH; i++) if (mv[i] && mwb[i]) inf++;
`ifdef ARM_PIPE_FWD_EN
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mv[i] && mwb[i] && md[i] == id_src1) f1 = i + 1;
      if (mv[i] && mwb[i] && id_two_src && md[i] == id_src2) f2 = i + 1;
    end
    h = id_valid && !flush && mld[0] && (f1 == 1 || f2 == 1);
    if (h) begin f1 = 0; f2 = 0; end
`else
    for (int i = 0; i < DEPTH; i++)
      if (mv[i] && mwb[i] && (md[i] == id_src1 || (id_two_src && md[i] == id_src2))) h = 1;
    h = h && id_valid && !flush;
`endif
    if (model_on) begin
      chk("hazard", hazard, h);
      chk("fwd_sel1", fwd_sel1, f1);
      chk("fwd_sel2", fwd_sel2, f2);
      chk("inflight", inflight, inf);
      chk("stall_count", stall_count, mstall);
    end
    exp_haz = h;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin mv[i] = 0; mwb[i] = 0; mld[i] = 0; md[i] = '0; end
      mstall   = 0;
      model_on = 1;
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        mv[i] = mv[i-1]; mwb[i] = mwb[i-1]; mld[i] = mld[i-1]; md[i] = md[i-1];
      end
      mv[0]  = id_valid && !h && !flush;
      mwb[0] = mv[0] && id_wb_en;
      mld[0] = mv[0] && id_mem_r_en;
      md[0]  = id_dest;
      if (h && mstall < SMAX) mstall++;
    end
  end

  // Drive one cycle of ID inputs, then return after the outputs have settled.
  task automatic cyc(input bit v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                     input bit t, input bit w, input bit l, input logic [AW-1:0] d,
                     input bit f, input bit r);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = t;
    id_wb_en = w; id_mem_r_en = l; id_dest = d; flush = f;
    @(negedge clk);
    #1;
  endtask

  // Present an instruction, holding it while the upstream freeze would; returns on issue cycle.
  task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input bit t,
                       input bit w, input bit l, input logic [AW-1:0] d, output int stalls);
    stalls = 0;
    cyc(1, s1, s2, t, w, l, d, 0, 0);
    while (exp_haz) begin
      stalls++;
      if (stalls > 8) begin
        checks++;
        failures++;
        $display("FAIL stall_bound: got %0d stall cycles expected at most 8", stalls);
        break;
      end
      cyc(1, s1, s2, t, w, l, d, 0, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    rst = 1; id_valid = 0; id_src1 = '0; id_src2 = '0; id_two_src = 0;
    id_wb_en = 0; id_mem_r_en = 0; id_dest = '0; flush = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_fwd1", fwd_sel1, 0);

    // ADD r1,r2,r3 ; ADD r2,r1,r3
    issue(2, 3, 1, 1, 0, 1, st);
    issue(1, 3, 1, 1, 0, 2, st);
`ifdef ARM_PIPE_FWD_EN
    chk("add_stalls", st, 0);
    chk("add_fwd1", fwd_sel1, 1);
    chk("add_stall_count", stall_count, 0);
`else
    chk("add_stalls", st, 2);
    chk("add_stall_count", stall_count, 2);
    chk("add_fwd1", fwd_sel1, 0);
`endif
    // one-cycle gap, then ORR r6,r2,r7
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(2, 7, 1, 1, 0, 6, st);
`ifdef ARM_PIPE_FWD_EN
    chk("gap_stalls", st, 0);
    chk("gap_fwd1", fwd_sel1, 2);
`else
    chk("gap_stalls", st, 1);
    chk("gap_stall_count", stall_count, 3);
`endif
    // LDR r4,[r8] ; SUB r5,r4,r6
    issue(8, 0, 0, 1, 1, 4, st);
    issue(4, 6, 1, 1, 0, 5, st);
`ifdef ARM_PIPE_FWD_EN
    chk("ldr_stalls", st, 1);
    chk("ldr_fwd1", fwd_sel1, 2);
    chk("ldr_fwd2", fwd_sel2, 0);
    chk("ldr_stall_count", stall_count, 1);
`else
    chk("ldr_stalls", st, 2);
    chk("ldr_stall_sat", stall_count, 3);
`endif
    // r1 written twice back to back, then read
    issue(12, 13, 1, 1, 0, 1, st);
    issue(11, 0, 0, 1, 0, 1, st);
    issue(1, 0, 0, 1, 0, 14, st);
`ifdef ARM_PIPE_FWD_EN
    chk("young_stalls", st, 0);
    chk("young_fwd1", fwd_sel1, 1);
`else
    chk("young_stalls", st, 2);
`endif
    // ADD r3 then a dependent reader squashed by flush
    issue(6, 0, 0, 1, 0, 3, st);
    cyc(1, 3, 0, 0, 1, 0, 9, 1, 0);
    chk("flush_hazard", hazard, 0);
    chk("flush_inflight", inflight, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_flush_inflight", inflight, 1);
    // R15 tracked like any register
    issue(0, 0, 0, 1, 0, 15, st);
    issue(15, 2, 1, 1, 0, 0, st);
`ifdef ARM_PIPE_FWD_EN
    chk("r15_fwd1", fwd_sel1, 1);
`else
    chk("r15_stalls", st, 2);
`endif
    // reset asserted during a load-use stall
    issue(9, 0, 0, 1, 1, 7, st);
    cyc(1, 7, 0, 0, 1, 0, 8, 0, 0);
    chk("midstall_hazard", hazard, 1);
    cyc(1, 7, 0, 0, 1, 0, 8, 0, 1);
    cyc(1, 7, 0, 0, 1, 0, 8, 0, 0);
    chk("post_rst_hazard", hazard, 0);
    chk("post_rst_inflight", inflight, 0);
    chk("post_rst_stall", stall_count, 0);
    chk("post_rst_fwd1", fwd_sel1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_inflight", inflight, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_inflight", inflight, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
